conv_stream_ctrl: RTL

Sequencing controller for the 5x5 line-buffer window generator (`conv_buffer`). It streams a WIDTH x HEIGHT image out of a single-port pixel memory into the buffer once per filter. It clears the buffer between passes and tags every emitted window with its row, column and filter index for the downstream MAC array. It sits between the image memory and `conv_buffer`, under a start/done handshake from the layer sequencer.

---
 rtl/conv_stream_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/conv_stream_ctrl.sv
// Sequencing controller: streams a WIDTH x HEIGHT image from pixel memory into conv_buffer
// once per filter, clearing the buffer between passes and tagging each emitted window.
module conv_stream_ctrl #(
    parameter int WIDTH         = 28,
    parameter int HEIGHT        = 28,
    parameter int DATA_BITS     = 8,
    parameter int FILTER_SIZE   = 5,
    parameter int NUM_FILTERS   = 6,
    parameter int ADDR_BITS     = 10,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 hold,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 mem_rd_en,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic [DATA_BITS-1:0] mem_rd_data,
    output logic                 buf_clr,
    output logic                 buf_in_val,
    output logic [DATA_BITS-1:0] buf_data,
    input  logic                 buf_valid,
    output logic                 win_valid,
    output logic [7:0]           win_row,
    output logic [7:0]           win_col,
    output logic [7:0]           filter_idx
);
    localparam int OUT_W    = WIDTH - FILTER_SIZE + 1;
    localparam int OUT_H    = HEIGHT - FILTER_SIZE + 1;
    localparam int NWIN     = OUT_W * OUT_H;
    localparam int NPIX     = WIDTH * HEIGHT;
    localparam int CNT_BITS = $clog2(NWIN + 1);
    localparam int TO_BITS  = $clog2(DRAIN_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t               state, state_nx;
    logic [ADDR_BITS-1:0] pixel_cnt;
    logic [CNT_BITS-1:0]  win_cnt;
    logic [TO_BITS-1:0]   timeout_cnt;
    logic                 in_window;
    logic                 win_adv;
    logic                 last_read;
    logic                 drain_full;
    logic                 timeout_hit;

    // Return path is a pure wire; memory latency alone lines data up with buf_in_val.
    assign buf_data = mem_rd_data;
    assign mem_addr = pixel_cnt;

    always_comb begin
        state_nx    = state;
        mem_rd_en   = 1'b0;
        buf_clr     = 1'b0;
        done        = 1'b0;
        busy        = 1'b0;
        in_window   = (state == S_STREAM) || (state == S_DRAIN);
        win_valid   = in_window && buf_valid;
        // Counting stops at NWIN so stray valids cannot push the row past the last one.
        win_adv     = win_valid && (win_cnt < CNT_BITS'(NWIN));
        last_read   = (state == S_STREAM) && !hold && (pixel_cnt == ADDR_BITS'(NPIX - 1));
        drain_full  = (win_cnt == CNT_BITS'(NWIN)) ||
                      (win_adv && (win_cnt == CNT_BITS'(NWIN - 1)));
        timeout_hit = !buf_valid && (timeout_cnt == TO_BITS'(DRAIN_TIMEOUT - 1));

        case (state)
            S_IDLE: begin
                if (start) state_nx = S_CLEAR;
            end
            S_CLEAR: begin
                busy     = 1'b1;
                buf_clr  = 1'b1;
                state_nx = S_STREAM;
            end
            S_STREAM: begin
                busy      = 1'b1;
                mem_rd_en = !hold;
                if (last_read) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (drain_full)       state_nx = S_NEXT;
                else if (timeout_hit) state_nx = S_DONE;
            end
            S_NEXT: begin
                busy = 1'b1;
                if (filter_idx == 8'(NUM_FILTERS - 1)) state_nx = S_DONE;
                else                                   state_nx = S_CLEAR;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_cnt   <= '0;
            win_cnt     <= '0;
            timeout_cnt <= '0;
            win_row     <= '0;
            win_col     <= '0;
            filter_idx  <= '0;
            err         <= 1'b0;
            buf_in_val  <= 1'b0;
        end else begin
            buf_in_val <= mem_rd_en;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        filter_idx <= '0;
                        err        <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    pixel_cnt   <= '0;
                    win_cnt     <= '0;
                    timeout_cnt <= '0;
                    win_row     <= '0;
                    win_col     <= '0;
                end
                S_STREAM: begin
                    if (!hold) pixel_cnt <= pixel_cnt + 1'b1;
                end
                S_DRAIN: begin
                    if (buf_valid) timeout_cnt <= '0;
                    else           timeout_cnt <= timeout_cnt + 1'b1;
                    if (timeout_hit && !drain_full) err <= 1'b1;
                end
                S_NEXT: begin
                    if (filter_idx != 8'(NUM_FILTERS - 1)) filter_idx <= filter_idx + 1'b1;
                end
                default: ;
            endcase

            // Tags describe the window presented this cycle and step after it.
            if (win_adv) begin
                win_cnt <= win_cnt + 1'b1;
                if (win_col == 8'(OUT_W - 1)) begin
                    win_col <= '0;
                    if (win_row != 8'(OUT_H - 1)) win_row <= win_row + 1'b1;
                end else begin
                    win_col <= win_col + 1'b1;
                end
            end
        end
    end
endmodule
